// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART transmit bundle for uart_tx_arbiter.
// Master drives requests and txrdy; slave is the arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   ack;
   logic [NUM_REQ-1:0]   grant;
   logic [7:0]           uart_data;
   logic                 uart_wr;
   logic                 txrdy;
   logic                 busy;

   modport master (
      output req, req_data, req_last, txrdy,
      input  ack, grant, uart_data, uart_wr, busy
   );

   modport slave (
      input  req, req_data, req_last, txrdy,
      output ack, grant, uart_data, uart_wr, busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter sharing one UART transmitter,
// with packet locking, post-write gap and lock timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int WR_GAP       = 2,
   parameter int LOCK_TIMEOUT = 255
) (
   input logic              clk,
   input logic              reset,
   uart_tx_arbiter_if.slave bus
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, SEND, GAP, HOLD} state_t;

   state_t        state;
   logic [PW-1:0] rr;
   logic [3:0]    gap_cnt;
   logic [7:0]    tmo_cnt;
   logic          lock;

   logic          found;
   logic [PW-1:0] win;
   logic [7:0]    win_data;
   logic          win_last;
   logic          own_req;
   logic [7:0]    own_data;
   logic          own_last;

   // Walk downward so the nearest requester above rr is chosen last.
   always_comb begin
      int j;
      logic [PW-1:0] idx;
      found = 1'b0;
      win   = '0;
      j     = 0;
      idx   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         j = int'(rr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         idx = PW'(j);
         if (bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      win_data = 8'h00;
      win_last = 1'b0;
      own_req  = 1'b0;
      own_data = 8'h00;
      own_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PW'(i) == win) begin
            win_data = bus.req_data[8*i +: 8];
            win_last = bus.req_last[i];
         end
         if (PW'(i) == rr) begin
            own_req  = bus.req[i];
            own_data = bus.req_data[8*i +: 8];
            own_last = bus.req_last[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         rr            <= PW'(NUM_REQ - 1);
         gap_cnt       <= '0;
         tmo_cnt       <= '0;
         lock          <= 1'b0;
         bus.ack       <= '0;
         bus.grant     <= '0;
         bus.uart_data <= 8'h00;
         bus.uart_wr   <= 1'b0;
      end else begin
         bus.ack     <= '0;
         bus.uart_wr <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.txrdy && found) begin
                  rr            <= win;
                  lock          <= !win_last;
                  bus.grant     <= NUM_REQ'(1) << win;
                  bus.ack       <= NUM_REQ'(1) << win;
                  bus.uart_data <= win_data;
                  bus.uart_wr   <= 1'b1;
                  tmo_cnt       <= '0;
                  state         <= SEND;
               end
            end
            SEND: begin
               gap_cnt <= 4'(WR_GAP - 1);
               state   <= GAP;
            end
            GAP: begin
               if (gap_cnt == 4'd0) begin
                  if (lock) begin
                     tmo_cnt <= '0;
                     state   <= HOLD;
                  end else begin
                     bus.grant <= '0;
                     state     <= IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            HOLD: begin
               if (own_req && bus.txrdy) begin
                  lock          <= !own_last;
                  bus.ack       <= bus.grant;
                  bus.uart_data <= own_data;
                  bus.uart_wr   <= 1'b1;
                  tmo_cnt       <= '0;
                  state         <= SEND;
               end else if (!own_req) begin
                  // Owner stalled mid-packet; release after the timeout.
                  if (tmo_cnt == 8'(LOCK_TIMEOUT - 1)) begin
                     bus.grant <= '0;
                     lock      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     tmo_cnt <= tmo_cnt + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state != IDLE) || (bus.grant != '0);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a
// randomized run against a packet-level round-robin model.
module tb_uart_tx_arbiter;
   localparam int N   = 4;
   localparam int GAP = 2;
   localparam int TMO = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(N), .WR_GAP(GAP), .LOCK_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int ncmp = 0;
   int nfail = 0;
   int cyc = 0;
   logic [8:0] q [N][$];
   bit en [N];
   bit wr_seen;
   int wr_idx;
   bit wr_last;
   int lcyc [$];
   int lidx [$];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      logic [8:0] e;
      for (int i = 0; i < N; i++) begin
         if (en[i] && q[i].size() > 0) begin
            e = q[i][0];
            bus.req[i] = 1'b1;
            bus.req_data[8*i +: 8] = e[7:0];
            bus.req_last[i] = e[8];
         end else begin
            bus.req[i] = 1'b0;
            bus.req_data[8*i +: 8] = 8'h00;
            bus.req_last[i] = 1'b0;
         end
      end
   endtask

   task automatic tick();
      logic [8:0] e;
      bit has;
      @(posedge clk);
      #1;
      cyc++;
      wr_seen = bus.uart_wr;
      wr_idx = -1;
      wr_last = 1'b0;
      chk("ack_count", $countones(bus.ack), bus.uart_wr ? 1 : 0);
      if (bus.uart_wr) begin
         for (int i = N - 1; i >= 0; i--)
            if (bus.ack[i]) wr_idx = i;
         has = (wr_idx >= 0) && (q[wr_idx].size() > 0);
         chk("wr_pending", 32'(has), 32'd1);
         if (has) begin
            e = q[wr_idx].pop_front();
            wr_last = e[8];
            chk("wr_data", bus.uart_data, e[7:0]);
         end
         lcyc.push_back(cyc);
         lidx.push_back(wr_idx);
      end
      drive();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.txrdy = 1'b0;
      for (int i = 0; i < N; i++) begin
         q[i].delete();
         en[i] = 1'b1;
      end
      drive();
      tick();
      tick();
      reset = 1'b0;
      lcyc.delete();
      lidx.delete();
   endtask

   task automatic wait_wr(input string tag, input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!wr_seen && n < budget);
      chk(tag, 32'(wr_seen), 32'd1);
   endtask

   task automatic push_pkt(input int i);
      int len;
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++)
         q[i].push_back({(k == len - 1), 8'($urandom)});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nw;
      int rowner;
      int lastw;
      bit inpkt;
      bit txr;
      bit expw;

      bus.req = '0;
      bus.req_data = '0;
      bus.req_last = '0;
      bus.txrdy = 1'b0;

      do_reset();
      chk("rst_ack", bus.ack, 0);
      chk("rst_grant", bus.grant, 0);
      chk("rst_data", bus.uart_data, 0);
      chk("rst_wr", bus.uart_wr, 0);
      chk("rst_busy", bus.busy, 0);

      q[0].push_back({1'b1, 8'hA5});
      bus.txrdy = 1'b1;
      drive();
      tick();
      chk("single_wr", bus.uart_wr, 1);
      chk("single_ack", bus.ack, 4'b0001);
      chk("single_data", bus.uart_data, 8'hA5);
      chk("single_grant", bus.grant, 4'b0001);
      tick();
      chk("single_gap1_wr", bus.uart_wr, 0);
      chk("single_gap1_busy", bus.busy, 1);
      tick();
      chk("single_gap2_grant", bus.grant, 4'b0001);
      tick();
      chk("single_idle_grant", bus.grant, 0);
      chk("single_idle_busy", bus.busy, 0);

      do_reset();
      q[0].push_back({1'b1, 8'h11});
      q[0].push_back({1'b1, 8'h15});
      q[1].push_back({1'b1, 8'h12});
      q[2].push_back({1'b1, 8'h13});
      q[3].push_back({1'b1, 8'h14});
      bus.txrdy = 1'b1;
      drive();
      repeat (5) wait_wr("rr_wait", 10);
      for (int k = 0; k < 5; k++)
         chk("rr_order", lidx[k], k % N);
      for (int k = 1; k < 5; k++)
         chk("rr_spacing", lcyc[k] - lcyc[k-1], GAP + 2);

      do_reset();
      q[2].push_back({1'b0, 8'h21});
      q[2].push_back({1'b0, 8'h22});
      q[2].push_back({1'b1, 8'h23});
      bus.txrdy = 1'b1;
      drive();
      for (int k = 0; k < 4; k++) begin
         wait_wr("lock_wait", 20);
         chk("lock_ack", bus.ack, (k < 3) ? 4'b0100 : 4'b0010);
         chk("lock_grant", bus.grant, (k < 3) ? 4'b0100 : 4'b0010);
         if (k == 0) begin
            q[1].push_back({1'b1, 8'h31});
            drive();
         end
      end

      do_reset();
      q[0].push_back({1'b1, 8'h41});
      q[1].push_back({1'b1, 8'h42});
      bus.txrdy = 1'b1;
      drive();
      wait_wr("stall_first", 10);
      chk("stall_first_ack", bus.ack, 4'b0001);
      bus.txrdy = 1'b0;
      nw = 0;
      repeat (22) begin
         tick();
         if (wr_seen) nw++;
      end
      chk("stall_nowr", nw, 0);
      bus.txrdy = 1'b1;
      tick();
      chk("stall_wr", bus.uart_wr, 1);
      chk("stall_ack", bus.ack, 4'b0010);

      do_reset();
      q[0].push_back({1'b0, 8'h51});
      q[0].push_back({1'b0, 8'h52});
      q[0].push_back({1'b1, 8'h53});
      q[3].push_back({1'b1, 8'h54});
      bus.txrdy = 1'b1;
      drive();
      wait_wr("tmo_first", 10);
      chk("tmo_first_ack", bus.ack, 4'b0001);
      en[0] = 1'b0;
      drive();
      repeat (GAP + TMO) tick();
      chk("tmo_held_grant", bus.grant, 4'b0001);
      tick();
      chk("tmo_drop_grant", bus.grant, 0);
      chk("tmo_drop_wr", bus.uart_wr, 0);
      tick();
      chk("tmo_next_wr", bus.uart_wr, 1);
      chk("tmo_next_ack", bus.ack, 4'b1000);

      do_reset();
      q[1].push_back({1'b0, 8'h61});
      q[1].push_back({1'b1, 8'h62});
      bus.txrdy = 1'b1;
      drive();
      wait_wr("rstgap_first", 10);
      chk("rstgap_first_ack", bus.ack, 4'b0010);
      tick();
      reset = 1'b1;
      tick();
      chk("rstgap_ack", bus.ack, 0);
      chk("rstgap_grant", bus.grant, 0);
      chk("rstgap_data", bus.uart_data, 0);
      chk("rstgap_wr", bus.uart_wr, 0);
      chk("rstgap_busy", bus.busy, 0);
      reset = 1'b0;
      q[0].push_back({1'b1, 8'h63});
      drive();
      tick();
      chk("rstgap_next_wr", bus.uart_wr, 1);
      chk("rstgap_next_ack", bus.ack, 4'b0001);

      // Every requester always has a packet waiting, so ownership
      // rotates packet by packet and a write lands on the first
      // txrdy-high decision cycle once the gap has elapsed.
      do_reset();
      rowner = N - 1;
      inpkt = 1'b0;
      lastw = -100;
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < N; i++)
            while (q[i].size() < 4) push_pkt(i);
         txr = ($urandom_range(0, 3) != 0);
         bus.txrdy = txr;
         drive();
         tick();
         expw = txr && (cyc - lastw >= GAP + 2);
         chk("rand_wr", 32'(wr_seen), 32'(expw));
         if (wr_seen) begin
            if (!inpkt) rowner = (rowner + 1) % N;
            chk("rand_owner", wr_idx, rowner);
            inpkt = !wr_last;
            lastw = cyc;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end
endmodule
